bbl_serial_subtractor: RTL and testbench
========================================

Name: bbl_serial_subtractor

Overview:
- Block-serial borrow look-ahead subtractor: the subtraction counterpart of the team's 14-bit block carry look-ahead adder.
- Computes D = X - Y on 14-bit unsigned operands, one BLOCK-bit slice per clock.
- Block borrow-generate/propagate is evaluated within each slice; the inter-block borrow is carried in a register.
- Sits behind a valid/ready input port and a valid/ready output port in the arithmetic datapath, so narrow area replaces the fully parallel structure.

Parameters:
- WIDTH, 14: operand width; result width is WIDTH+1.
- BLOCK, 4: bits processed per cycle. NB = ceil(WIDTH/BLOCK) (4 at defaults). Last block holds WIDTH-(NB-1)*BLOCK bits (2 at defaults). Legal range 1 <= BLOCK <= WIDTH.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; synchronous and active-high.
- IN_VALID  in  1  operand pair present.
- IN_READY  out  1  block can accept operands.
- X  in  WIDTH  minuend, unsigned.
- Y  in  WIDTH  subtrahend, unsigned.
- OUT_VALID  out  1  result D valid.
- OUT_READY  in  1  consumer takes result.
- D  out  WIDTH+1  D[WIDTH-1:0] = (X-Y) mod 2^WIDTH; D[WIDTH] = borrow-out (1 iff X < Y). Equivalently, D is the 15-bit two's-complement value of X-Y.

Behaviour:
- Reset (RST=1 at an edge, any state, including mid-operation):
  - state=IDLE, IN_READY=1, OUT_VALID=0, D=0, block index=0, borrow register=0.
  - Any in-flight operation is discarded; no partial result is ever presented.
- States: IDLE, RUN, DONE.
  - IN_READY=1 only in IDLE.
  - OUT_VALID=1 only in DONE.
  - Both are registered (state-decoded) outputs, not functions of IN_VALID or OUT_READY.
- IDLE:
  - On IN_VALID=1 at an edge: latch X and Y into operand registers, clear D to 0, set borrow=0 and index=0, go to RUN.
  - X and Y changes after acceptance have no effect.
- RUN: one block per edge, block i covering bits [i*BLOCK +: width_i].
  - Per bit: g = ~x & y (borrow generate); p = ~(x ^ y) (borrow propagate).
  - Internal bit borrows use look-ahead: b[j+1] = g[j] | (p[j] & b[j]), with b[0] = borrow register.
  - Per bit: d[j] = x[j] ^ y[j] ^ b[j].
  - Write d into the D slice. Borrow register <= block borrow-out = Gblk | (Pblk & borrow), with Gblk/Pblk formed as in a BCLA unit. Increment index.
  - On the edge processing block NB-1: also write D[WIDTH] = final borrow, go to DONE.
- Latency:
  - Acceptance at edge k; blocks processed at edges k+1 .. k+NB.
  - OUT_VALID=1 in the cycle after edge k+NB (4 cycles after acceptance at defaults).
- DONE:
  - Hold D and OUT_VALID=1 for as long as OUT_READY=0.
  - On OUT_READY=1 at an edge: OUT_VALID<=0, go to IDLE. D retains its value until the next acceptance.
  - No same-cycle bypass, so minimum initiation interval = NB+2 cycles (6 at defaults).
- Ignored inputs:
  - IN_VALID is ignored outside IDLE.
  - OUT_READY is ignored outside DONE.
- During RUN, D is partially updated. Consumers must qualify D with OUT_VALID.
- No X propagation from unused operand bits. The partial last block uses only its valid bits.

Test Plan:
- Basic: reset, then X=100, Y=37 with IN_VALID=1 and OUT_READY=1.
  - Accepted in the first IDLE cycle; OUT_VALID rises 4 cycles later.
  - D=0x003F (D[14]=0); one-cycle OUT_VALID pulse, then IN_READY=1 the cycle after.
- Full-width borrow ripple: X=0, Y=1.
  - D=0x7FFF: D[13:0]=0x3FFF, D[14]=1.
  - The borrow register must be 1 after each of the 4 blocks.
- Edge operands:
  - X=0x3FFF, Y=0x3FFF -> D=0x0000.
  - X=0x3FFF, Y=0 -> D=0x3FFF.
  - X=0, Y=0x3FFF -> D=0x4001.
  - X=0x2000, Y=0x1FFF -> D=0x0001 (borrow crosses into the partial block 3).
- Backpressure: complete X=9, Y=5 with OUT_READY=0 for 10 cycles, while IN_VALID pulses with X=1, Y=2.
  - D=0x0004 and OUT_VALID=1 held throughout; IN_READY=0 throughout.
  - The second operand pair is not accepted.
  - Raise OUT_READY -> IDLE next cycle; the second pair is then accepted only if still presented.
- Reset mid-RUN: assert RST at the second RUN edge.
  - Next cycle: IN_READY=1, OUT_VALID=0, D=0.
  - A following transaction X=5, Y=9 yields D=0x7FFC with no corruption from the aborted borrow.
- Streaming: IN_VALID and OUT_READY held at 1 with a new pair each acceptance.
  - One result every 6 cycles; 50 random pairs checked against the 15-bit two's-complement reference X-Y.
  - Repeat with BLOCK=1, 3 and 14 (NB=14, 5, 1).

Source files
------------

// File: rtl/bbl_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module   : bbl_serial_subtractor_if
//  Purpose  : Operand/result handshake bundle for the block-serial
//             borrow look-ahead subtractor.
//  Signals  : in_valid/in_ready/x/y   - operand pair handshake (to subtractor)
//             out_valid/out_ready/d   - result handshake (from subtractor)
//  Modports : slave  - subtractor side
//             master - producer/consumer side
//  Revision : 1.0 - initial release
// ============================================================================
interface bbl_serial_subtractor_if #(
  parameter int WIDTH = 14
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   d;

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, d
  );

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, d
  );
endinterface
`default_nettype wire

// File: rtl/bbl_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : bbl_serial_subtractor
//  Purpose  : D = X - Y on WIDTH-bit unsigned operands, BLOCK bits per clock.
//             Borrow generate/propagate is resolved inside each slice; the
//             inter-block borrow lives in a register.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             s_if - slave modport: in_valid/in_ready/x/y operand handshake,
//                    out_valid/out_ready/d result handshake.
//                    d[WIDTH] is the borrow-out (1 iff X < Y).
//  Revision : 1.0 - initial release
// ============================================================================
module bbl_serial_subtractor #(
  parameter int WIDTH = 14,
  parameter int BLOCK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bbl_serial_subtractor_if.slave s_if
);

  localparam int c_nb   = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int c_last = WIDTH - (c_nb - 1) * BLOCK;
  localparam int c_iw   = (c_nb > 1) ? $clog2(c_nb) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_y;
  logic [WIDTH:0]    r_d;
  logic [c_iw-1:0]   r_idx;
  logic              r_borrow;

  logic              w_last;
  int unsigned       w_shift;
  int                w_nbits;
  logic [BLOCK-1:0]  w_mask;
  logic [BLOCK-1:0]  w_xs;
  logic [BLOCK-1:0]  w_ys;
  logic [BLOCK-1:0]  w_g;
  logic [BLOCK-1:0]  w_p;
  logic [BLOCK-1:0]  w_dblk;
  logic              w_bchain;
  logic              w_gblk;
  logic              w_pblk;
  logic              w_bout;
  logic [WIDTH:0]    w_smask;
  logic [WIDTH:0]    w_sval;
  logic [WIDTH:0]    w_d_nxt;

  // Handshake outputs are pure state decodes.
  assign s_if.in_ready  = (r_state == S_IDLE);
  assign s_if.out_valid = (r_state == S_DONE);
  assign s_if.d         = r_d;

  // ---------------------------------------------------------------- slice
  assign w_last  = (r_idx == c_iw'(c_nb - 1));
  assign w_shift = 32'(r_idx) * 32'(BLOCK);
  assign w_xs    = BLOCK'(r_x >> w_shift);
  assign w_ys    = BLOCK'(r_y >> w_shift);

  // Bits above the partial last block are forced to g=0/p=1 so they pass
  // the incoming borrow through untouched and never reach the result.
  always_comb begin
    w_nbits = w_last ? c_last : BLOCK;
    w_mask  = '0;
    for (int j = 0; j < BLOCK; j++) begin
      w_mask[j] = (j < w_nbits);
    end
  end

  assign w_g = ~w_xs & w_ys & w_mask;
  assign w_p = ~(w_xs ^ w_ys) | ~w_mask;

  // Bit borrows feed the difference bits; Gblk/Pblk form the block borrow.
  always_comb begin
    w_bchain = r_borrow;
    w_gblk   = 1'b0;
    w_pblk   = 1'b1;
    w_dblk   = '0;
    for (int j = 0; j < BLOCK; j++) begin
      w_dblk[j] = w_xs[j] ^ w_ys[j] ^ w_bchain;
      w_bchain  = w_g[j] | (w_p[j] & w_bchain);
      w_gblk    = w_g[j] | (w_p[j] & w_gblk);
      w_pblk    = w_pblk & w_p[j];
    end
    w_bout = w_gblk | (w_pblk & r_borrow);
  end

  assign w_smask = (WIDTH + 1)'(w_mask) << w_shift;
  assign w_sval  = (WIDTH + 1)'(w_dblk & w_mask) << w_shift;

  always_comb begin
    w_d_nxt = (r_d & ~w_smask) | w_sval;
    if (w_last) begin
      w_d_nxt[WIDTH] = w_bout;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (s_if.in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)         w_state_nxt = S_DONE;
      S_DONE:  if (s_if.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_d      <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_if.in_valid) begin
            r_x      <= s_if.x;
            r_y      <= s_if.y;
            r_d      <= '0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
          end
        end
        S_RUN: begin
          r_d      <= w_d_nxt;
          r_borrow <= w_bout;
          r_idx    <= r_idx + c_iw'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bbl_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bbl_serial_subtractor
//  Purpose  : Directed self-checking bench for bbl_serial_subtractor at the
//             default geometry, plus streaming instances at BLOCK=1,3,4,14.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bbl_serial_subtractor;

  localparam int c_w  = 14;
  localparam int c_nb = 4;

  logic clk;
  logic rst;
  logic rst_s;
  int   n_vec;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bbl_serial_subtractor_if #(.WIDTH(c_w)) m_if ();

  bbl_serial_subtractor #(.WIDTH(c_w), .BLOCK(4)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (m_if.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
    end
  endtask

  // One full transaction with OUT_READY high; optionally watches the borrow
  // register after every block.
  task automatic run_op(input string tag, input logic [13:0] xv, input logic [13:0] yv,
                        input logic [14:0] exp_d, input bit chk_b);
    int j;
    @(negedge clk);
    m_if.x = xv; m_if.y = yv; m_if.in_valid = 1'b1; m_if.out_ready = 1'b1;
    check_val({tag, "_in_ready"}, 32'(m_if.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    m_if.in_valid = 1'b0; m_if.x = '1; m_if.y = 14'h1555;
    j = 0;
    while (!m_if.out_valid && j < 20) begin
      @(negedge clk);
      j++;
      if (chk_b && j <= c_nb) check_val({tag, "_borrow"}, 32'(u_dut.r_borrow), 32'd1);
    end
    check_val({tag, "_latency"}, 32'(j), 32'(c_nb));
    check_val({tag, "_d"}, 32'(m_if.d), 32'(exp_d));
    check_val({tag, "_busy"}, 32'(m_if.in_ready), 32'd0);
    @(negedge clk);
    check_val({tag, "_pulse"}, 32'(m_if.out_valid), 32'd0);
    check_val({tag, "_idle"}, 32'(m_if.in_ready), 32'd1);
  endtask

  // ---------------------------------------------------------------- streaming
  for (genvar gi = 0; gi < 4; gi++) begin : g_stream
    localparam int BLK = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 4 : 14;
    localparam int BNB = (c_w + BLK - 1) / BLK;
    bit done;

    bbl_serial_subtractor_if #(.WIDTH(c_w)) u_if ();

    bbl_serial_subtractor #(.WIDTH(c_w), .BLOCK(BLK)) u_dut (
      .clk  (clk),
      .rst  (rst_s),
      .s_if (u_if.slave)
    );

    initial begin
      logic [13:0] xv;
      logic [13:0] yv;
      logic [14:0] ev;
      longint      t_acc;
      longint      t_prev;
      int          wt;
      done = 1'b0;
      u_if.in_valid = 1'b0; u_if.out_ready = 1'b1; u_if.x = '0; u_if.y = '0;
      t_prev = 0;
      repeat (5) @(negedge clk);
      for (int n = 0; n < 50; n++) begin
        xv = 14'($urandom);
        yv = 14'($urandom);
        ev = {1'b0, xv} - {1'b0, yv};
        u_if.x = xv; u_if.y = yv; u_if.in_valid = 1'b1;
        wt = 0;
        while (!u_if.in_ready && wt < 100) begin @(negedge clk); wt++; end
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        wt = 0;
        while (!u_if.out_valid && wt < 100) begin @(negedge clk); wt++; end
        check_val($sformatf("stream_b%0d_d", BLK), 32'(u_if.d), 32'(ev));
        if (n > 0) check_val($sformatf("stream_b%0d_interval", BLK),
                             32'((t_acc - t_prev) / 10), 32'(BNB + 2));
        t_prev = t_acc;
      end
      u_if.in_valid = 1'b0;
      done = 1'b1;
    end
  end

  // ---------------------------------------------------------------- directed
  initial begin
    int wt;
    n_vec = 0; n_err = 0;
    rst = 1'b1; rst_s = 1'b1;
    m_if.in_valid = 1'b0; m_if.out_ready = 1'b0; m_if.x = '0; m_if.y = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst_s = 1'b0;
    check_val("rst_in_ready", 32'(m_if.in_ready), 32'd1);
    check_val("rst_out_valid", 32'(m_if.out_valid), 32'd0);
    check_val("rst_d", 32'(m_if.d), 32'd0);

    run_op("basic",    14'd100,   14'd37,    15'h003F, 1'b0);
    run_op("ripple",   14'd0,     14'd1,     15'h7FFF, 1'b1);
    run_op("max_max",  14'h3FFF,  14'h3FFF,  15'h0000, 1'b0);
    run_op("max_zero", 14'h3FFF,  14'h0000,  15'h3FFF, 1'b0);
    run_op("zero_max", 14'h0000,  14'h3FFF,  15'h4001, 1'b0);
    run_op("partial",  14'h2000,  14'h1FFF,  15'h0001, 1'b0);

    // Backpressure with a competing operand pair held at the input.
    @(negedge clk);
    m_if.x = 14'd9; m_if.y = 14'd5; m_if.in_valid = 1'b1; m_if.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_if.x = 14'd1; m_if.y = 14'd2;
    wt = 0;
    while (!m_if.out_valid && wt < 20) begin @(negedge clk); wt++; end
    for (int c = 0; c < 10; c++) begin
      check_val("bp_out_valid", 32'(m_if.out_valid), 32'd1);
      check_val("bp_d", 32'(m_if.d), 32'h0004);
      check_val("bp_in_ready", 32'(m_if.in_ready), 32'd0);
      @(negedge clk);
    end
    m_if.out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_release_idle", 32'(m_if.in_ready), 32'd1);
    check_val("bp_release_valid", 32'(m_if.out_valid), 32'd0);
    check_val("bp_d_retained", 32'(m_if.d), 32'h0004);
    @(negedge clk);
    m_if.in_valid = 1'b0;
    wt = 0;
    while (!m_if.out_valid && wt < 20) begin @(negedge clk); wt++; end
    check_val("bp_second_d", 32'(m_if.d), 32'h7FFF);
    @(negedge clk);

    // Reset landing on the second RUN edge.
    @(negedge clk);
    m_if.x = 14'd0; m_if.y = 14'd1; m_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_if.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_in_ready", 32'(m_if.in_ready), 32'd1);
    check_val("midrst_out_valid", 32'(m_if.out_valid), 32'd0);
    check_val("midrst_d", 32'(m_if.d), 32'd0);
    check_val("midrst_borrow", 32'(u_dut.r_borrow), 32'd0);
    repeat (6) begin
      @(negedge clk);
      check_val("midrst_quiet", 32'(m_if.out_valid), 32'd0);
    end
    run_op("after_rst", 14'd5, 14'd9, 15'h7FFC, 1'b0);

    wt = 0;
    while (!(g_stream[0].done && g_stream[1].done && g_stream[2].done && g_stream[3].done)
           && wt < 5000) begin
      @(negedge clk);
      wt++;
    end
    check_val("stream_done", 32'({g_stream[3].done, g_stream[2].done,
                                  g_stream[1].done, g_stream[0].done}), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
